// File: rtl/rd_outfifo_pkg.sv
// rd_outfifo_pkg: state encoding and default geometry for the output FIFO read side.
package rd_outfifo_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_e;
    localparam int LINE_WORDS_DEF = 320;
    localparam int CNT_W_DEF      = 10;
endpackage

// File: rtl/rd_outfifo.sv
// rd_outfifo: pops 16-bit FIFO words and serialises them high byte first onto a byte stream with a per-line last flag.
module rd_outfifo
    import rd_outfifo_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clk_108m,
    input  logic        rst_n,
    input  logic        out_fifo_empty,
    output logic        out_fifo_rden,
    input  logic [15:0] out_fifo_rdata,
    input  logic        flush,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);
    state_e           state_q, state_d;
    logic [15:0]      word_buf_q, word_buf_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]       dout_q, dout_d;
    logic             rd_req, lo_acc, at_end;
    always_comb begin
        rd_req = ~flush & ~out_fifo_empty & ((state_q == IDLE) | ((state_q == LO) & dout_ready));
        lo_acc = ~flush & (state_q == LO) & dout_ready;
        at_end = wcnt_q == LAST_CNT;
        state_d = flush ? IDLE :
                  state_q == IDLE ? (out_fifo_empty ? IDLE : LOAD) :
                  state_q == LOAD ? HI :
                  state_q == HI   ? (dout_ready ? LO : HI) :
                  dout_ready      ? (out_fifo_empty ? IDLE : LOAD) : LO;
        word_buf_d = ((state_q == LOAD) & ~flush) ? out_fifo_rdata : word_buf_q;
        wcnt_d = flush ? '0 : lo_acc ? (at_end ? '0 : wcnt_q + CNT_W'(1)) : wcnt_q;
        // dout is registered so the stream outputs never see a combinational input path
        dout_d = state_d == HI ? word_buf_d[15:8] :
                 state_d == LO ? word_buf_d[7:0] : dout_q;
    end
    always_ff @(posedge clk_108m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_buf_q <= '0;
            wcnt_q     <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_buf_q <= word_buf_d;
            wcnt_q     <= wcnt_d;
            dout_q     <= dout_d;
        end
    end
    assign out_fifo_rden = rst_n & rd_req;
    assign dout          = dout_q;
    assign dout_valid    = (state_q == HI) | (state_q == LO);
    assign dout_last     = (state_q == LO) & at_end;
endmodule

// File: tb/tb_rd_outfifo.sv
// tb_rd_outfifo: scoreboard bench with a queue-backed FIFO model and a line length of 4 words.
module tb_rd_outfifo;
    logic        clk_108m = 0;
    logic        rst_n = 0;
    logic        out_fifo_empty = 1;
    logic        out_fifo_rden;
    logic [15:0] out_fifo_rdata = '0;
    logic        flush = 0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 0;
    logic        dout_last;
    int checks = 0, failures = 0, rden_cnt = 0, last_cnt = 0, mcnt = 0;
    logic [15:0] fifo[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  e;

    always #5 clk_108m = ~clk_108m;

    rd_outfifo #(.LINE_WORDS(4), .CNT_W(2)) dut (
        .clk_108m(clk_108m), .rst_n(rst_n), .out_fifo_empty(out_fifo_empty),
        .out_fifo_rden(out_fifo_rden), .out_fifo_rdata(out_fifo_rdata), .flush(flush),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last)
    );

    // FIFO model: data one cycle after rden, empty flag updated the cycle after a read
    always @(posedge clk_108m) begin
        if (out_fifo_rden) begin
            rden_cnt++;
            checks++;
            if (fifo.size() == 0) begin
                failures++;
                $display("FAIL overread rden with fifo size=0 required size>0");
            end else
                out_fifo_rdata <= fifo.pop_front();
            out_fifo_empty <= (fifo.size() == 0);
        end
    end

    always @(negedge clk_108m) begin
        if (rst_n && dout_valid && dout_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got last=%b dout=%h required no byte", dout_last, dout);
            end else begin
                e = exp_q.pop_front();
                if ({dout_last, dout} !== e) begin
                    failures++;
                    $display("FAIL sb_byte got last=%b dout=%h required last=%b dout=%h", dout_last, dout, e[8], e[7:0]);
                end
            end
            if (dout_last) last_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required finish earlier", $time);
        $fatal(1);
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk_108m);
        #1;
    endtask

    task automatic push_word(logic [15:0] w, bit expect_out);
        fifo.push_back(w);
        out_fifo_empty = 0;
        if (expect_out) begin
            exp_q.push_back({1'b0, w[15:8]});
            exp_q.push_back({mcnt == 3, w[7:0]});
            mcnt = (mcnt + 1) % 4;
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < 200) begin
            cyc(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || dout_valid) begin
            failures++;
            $display("FAIL %s_drain pending=%0d valid=%b required 0 and 0", name, exp_q.size(), dout_valid);
        end
    endtask

    task automatic pulse_flush();
        flush = 1;
        cyc(1);
        flush = 0;
        mcnt = 0;
    endtask

    // Called at posedge+1 with the DUT idle and ready high; either releases reset or pushes w.
    task automatic check_latency(logic [15:0] w, string name, bit release_rst);
        int base = rden_cnt;
        if (release_rst) rst_n = 1;
        else push_word(w, 1);
        @(negedge clk_108m);
        checks++;
        if (out_fifo_rden !== 1 || dout_valid !== 0) begin
            failures++;
            $display("FAIL %s_t0 rden=%b valid=%b required 1 0", name, out_fifo_rden, dout_valid);
        end
        @(negedge clk_108m);
        checks++;
        if (out_fifo_rden !== 0 || dout_valid !== 0) begin
            failures++;
            $display("FAIL %s_t1 rden=%b valid=%b required 0 0", name, out_fifo_rden, dout_valid);
        end
        @(negedge clk_108m);
        checks++;
        if (dout_valid !== 1 || dout !== w[15:8]) begin
            failures++;
            $display("FAIL %s_t2 valid=%b dout=%h required 1 %h", name, dout_valid, dout, w[15:8]);
        end
        @(negedge clk_108m);
        checks++;
        if (dout_valid !== 1 || dout !== w[7:0] || out_fifo_rden !== 0) begin
            failures++;
            $display("FAIL %s_t3 valid=%b dout=%h rden=%b required 1 %h 0", name, dout_valid, dout, out_fifo_rden, w[7:0]);
        end
        cyc(1);
        wait_drain(name);
        checks++;
        if (rden_cnt - base != 1) begin
            failures++;
            $display("FAIL %s_rden_count got=%0d required 1", name, rden_cnt - base);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        dout_ready = 1;
        mcnt = 0;
        push_word(16'h1111, 1);
        cyc(3);
        @(negedge clk_108m);
        checks++;
        if (out_fifo_rden !== 0 || dout_valid !== 0 || dout !== 8'h00 || dout_last !== 0) begin
            failures++;
            $display("FAIL reset_out rden=%b valid=%b dout=%h last=%b required 0 0 00 0", out_fifo_rden, dout_valid, dout, dout_last);
        end
        cyc(1);
        check_latency(16'h1111, "reset_release", 1);
    endtask

    task automatic test_single();
        check_latency(16'hA55A, "single", 0);
    endtask

    task automatic test_back_pressure();
        int base = rden_cnt;
        int n = 0;
        dout_ready = 0;
        push_word(16'h1234, 1);
        push_word(16'h5678, 1);
        while (!dout_valid && n < 10) begin
            cyc(1);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_108m);
            checks++;
            if (dout_valid !== 1 || dout !== 8'h12 || out_fifo_rden !== 0 || rden_cnt - base != 1) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b dout=%h rden=%b reads=%0d required 1 12 0 1", i, dout_valid, dout, out_fifo_rden, rden_cnt - base);
            end
        end
        @(posedge clk_108m);
        #1;
        dout_ready = 1;
        @(negedge clk_108m);
        @(negedge clk_108m);
        checks++;
        if (dout !== 8'h34 || out_fifo_rden !== 1) begin
            failures++;
            $display("FAIL bp_lo dout=%h rden=%b required 34 1", dout, out_fifo_rden);
        end
        cyc(1);
        wait_drain("bp");
        checks++;
        if (rden_cnt - base != 2) begin
            failures++;
            $display("FAIL bp_reads got=%0d required 2", rden_cnt - base);
        end
    endtask

    task automatic test_line_flag();
        int base;
        pulse_flush();
        base = last_cnt;
        dout_ready = 1;
        for (int i = 1; i <= 9; i++) push_word(16'(i), 1);
        wait_drain("line");
        checks++;
        if (last_cnt - base != 2) begin
            failures++;
            $display("FAIL line_last_count got=%0d required 2", last_cnt - base);
        end
    endtask

    task automatic test_flush();
        int base, lbase;
        pulse_flush();
        dout_ready = 1;
        push_word(16'h0102, 1);
        push_word(16'h0304, 1);
        wait_drain("flush_pre");
        base = rden_cnt;
        push_word(16'hBEEF, 0);
        cyc(1);
        flush = 1;
        cyc(1);
        flush = 0;
        mcnt = 0;
        cyc(3);
        checks++;
        if (dout_valid !== 0 || rden_cnt - base != 1) begin
            failures++;
            $display("FAIL flush_drop valid=%b reads=%0d required 0 1", dout_valid, rden_cnt - base);
        end
        lbase = last_cnt;
        for (int i = 1; i <= 4; i++) push_word(16'h1000 + 16'(i), 1);
        wait_drain("flush_post");
        checks++;
        if (last_cnt - lbase != 1) begin
            failures++;
            $display("FAIL flush_last_count got=%0d required 1", last_cnt - lbase);
        end
    endtask

    task automatic test_accept_empty();
        dout_ready = 1;
        check_latency(16'hC0DE, "acc_empty", 0);
        cyc(3);
        check_latency(16'h7E57, "idle_again", 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_line_flag();
        test_flush();
        test_accept_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
